// File: rtl/rx_link_align_ctrl_pkg.sv
// rx_link_pkg: shared state encoding, default COM symbol and counter-width helper for rx_link_align_ctrl
package rx_link_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEARCH  = 3'd1,
    SLIP    = 3'd2,
    CONFIRM = 3'd3,
    ACTIVE  = 3'd4
  } state_t;
  localparam logic [7:0] COM_SYM_DEF = 8'hBC;
  function automatic int cnt_w(input int v);
    return v < 2 ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/rx_link_align_ctrl_if.sv
// rx_link_align_ctrl_if: byte bus from deserializer (enable/data_in/byte_valid/sym_err) and link outputs (slip_req/active_to_PS/valid_out_to_LDMX/data2send_to_LDMX/state_o, plus slip_count/lock_loss_count under RX_LINK_STATS_EN)
interface rx_link_align_ctrl_if;
  logic       enable;
  logic [7:0] data_in;
  logic       byte_valid;
  logic       sym_err;
  logic       slip_req;
  logic       active_to_PS;
  logic       valid_out_to_LDMX;
  logic [7:0] data2send_to_LDMX;
  logic [2:0] state_o;
`ifdef RX_LINK_STATS_EN
  logic [7:0] slip_count;
  logic [7:0] lock_loss_count;
  modport master (output enable, data_in, byte_valid, sym_err,
                  input slip_req, active_to_PS, valid_out_to_LDMX, data2send_to_LDMX, state_o,
                  slip_count, lock_loss_count);
  modport slave (input enable, data_in, byte_valid, sym_err,
                 output slip_req, active_to_PS, valid_out_to_LDMX, data2send_to_LDMX, state_o,
                 slip_count, lock_loss_count);
`else
  modport master (output enable, data_in, byte_valid, sym_err,
                  input slip_req, active_to_PS, valid_out_to_LDMX, data2send_to_LDMX, state_o);
  modport slave (input enable, data_in, byte_valid, sym_err,
                 output slip_req, active_to_PS, valid_out_to_LDMX, data2send_to_LDMX, state_o);
`endif
endinterface

// File: rtl/rx_link_align_ctrl_sat_counter.sv
// rx_sat_counter: 8-bit event counter (clk, rst, inc -> count) that sticks at 8'hFF and clears only on rst
module rx_sat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] count
);
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (inc && count != 8'hFF) count <= count + 8'd1;
  end
endmodule

// File: rtl/rx_link_align_ctrl.sv
// rx_link_align_ctrl: COM hunt, bit-slip request, lock/loss FSM and payload forwarding on clk_4f with sync reset; bus via rx_link_align_ctrl_if.slave; RX_LINK_STATS_EN adds slip/lock-loss counters
import rx_link_pkg::*;
module rx_link_align_ctrl #(
  parameter logic [7:0] COM_SYM       = COM_SYM_DEF,
  parameter int         LOCK_COUNT    = 4,
  parameter int         SEARCH_WINDOW = 16,
  parameter int         SLIP_WAIT     = 3,
  parameter int         LOSS_COUNT    = 3
) (
  input logic                 clk_4f,
  input logic                 reset,
  rx_link_align_ctrl_if.slave bus
);
  localparam int WW = cnt_w(SEARCH_WINDOW);
  localparam int CW = cnt_w(LOCK_COUNT);
  localparam int SW = cnt_w(SLIP_WAIT);
  localparam int EW = cnt_w(LOSS_COUNT);
  localparam logic [WW-1:0] WIN_LAST  = WW'(SEARCH_WINDOW - 1);
  localparam logic [CW-1:0] COM_LAST  = CW'(LOCK_COUNT - 1);
  localparam logic [SW-1:0] WAIT_LAST = SW'(SLIP_WAIT - 1);
  localparam logic [EW-1:0] ERR_LAST  = EW'(LOSS_COUNT - 1);
  state_t        state;
  logic [WW-1:0] win_cnt;
  logic [CW-1:0] com_cnt;
  logic [SW-1:0] wait_cnt;
  logic [EW-1:0] err_cnt;
  logic          is_com;
  assign is_com = bus.data_in == COM_SYM;
  assign bus.state_o = state;
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state                 <= IDLE;
      win_cnt               <= '0;
      com_cnt               <= '0;
      wait_cnt              <= '0;
      err_cnt               <= '0;
      bus.slip_req          <= 1'b0;
      bus.active_to_PS      <= 1'b0;
      bus.valid_out_to_LDMX <= 1'b0;
      bus.data2send_to_LDMX <= '0;
    end else if (!bus.enable) begin
      state                 <= IDLE;
      win_cnt               <= '0;
      com_cnt               <= '0;
      wait_cnt              <= '0;
      err_cnt               <= '0;
      bus.slip_req          <= 1'b0;
      bus.active_to_PS      <= 1'b0;
      bus.valid_out_to_LDMX <= 1'b0;
    end else begin
      bus.slip_req          <= 1'b0;
      bus.valid_out_to_LDMX <= 1'b0;
      case (state)
        IDLE: begin
          state   <= SEARCH;
          win_cnt <= '0;
        end
        SEARCH: if (bus.byte_valid) begin
          if (is_com) begin
            state   <= CONFIRM;
            com_cnt <= CW'(1);
          end else if (win_cnt == WIN_LAST) begin
            state        <= SLIP;
            bus.slip_req <= 1'b1;
            wait_cnt     <= '0;
            win_cnt      <= '0;
          end else win_cnt <= win_cnt + WW'(1);
        end
        SLIP: begin
          if (wait_cnt == WAIT_LAST) begin
            state   <= SEARCH;
            win_cnt <= '0;
          end else wait_cnt <= wait_cnt + SW'(1);
        end
        CONFIRM: if (bus.byte_valid) begin
          if (is_com && !bus.sym_err) begin
            if (com_cnt == COM_LAST) begin
              state            <= ACTIVE;
              bus.active_to_PS <= 1'b1;
              com_cnt          <= '0;
              err_cnt          <= '0;
            end else com_cnt <= com_cnt + CW'(1);
          end else begin
            state   <= SEARCH;
            win_cnt <= '0;
            com_cnt <= '0;
          end
        end
        ACTIVE: if (bus.byte_valid) begin
          if (bus.sym_err) begin
            if (err_cnt == ERR_LAST) begin
              state            <= SEARCH;
              bus.active_to_PS <= 1'b0;
              win_cnt          <= '0;
              err_cnt          <= '0;
            end else err_cnt <= err_cnt + EW'(1);
          end else begin
            err_cnt <= '0;
            if (!is_com) begin
              bus.valid_out_to_LDMX <= 1'b1;
              bus.data2send_to_LDMX <= bus.data_in;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef RX_LINK_STATS_EN
  logic loss_evt;
  assign loss_evt = !reset && bus.enable && state == ACTIVE && bus.byte_valid && bus.sym_err && err_cnt == ERR_LAST;
  rx_sat_counter u_slip_cnt (.clk(clk_4f), .rst(reset), .inc(bus.slip_req), .count(bus.slip_count));
  rx_sat_counter u_loss_cnt (.clk(clk_4f), .rst(reset), .inc(loss_evt), .count(bus.lock_loss_count));
`endif
endmodule

// File: tb/tb_rx_link_align_ctrl.sv
// tb_rx_link_align_ctrl: directed vectors with an event scoreboard for rx_link_align_ctrl
module tb_rx_link_align_ctrl;
  localparam logic [1:0] K_RISE = 2'd0, K_FALL = 2'd1, K_SLIP = 2'd2, K_PAY = 2'd3;
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] d;
  } ev_t;
  logic clk_4f = 1'b0;
  logic reset;
  int n_chk = 0;
  int n_fail = 0;
  bit mon_on = 1'b0;
  logic prev_act = 1'b0;
  logic prev_slip = 1'b0;
  ev_t q[$];
  rx_link_align_ctrl_if bus ();
  rx_link_align_ctrl dut (.clk_4f(clk_4f), .reset(reset), .bus(bus));
  always #5 clk_4f = ~clk_4f;
  task automatic expect_ev(input logic [1:0] k, input logic [7:0] d);
    q.push_back('{kind: k, d: d});
  endtask
  task automatic chk_ev(input logic [1:0] k, input logic [7:0] d);
    ev_t e;
    n_chk++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL event: got kind %0d data %h at %0t, nothing expected", k, d, $time);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.d != d) begin
        n_fail++;
        $display("FAIL event: got kind %0d data %h at %0t, required kind %0d data %h", k, d, $time, e.kind, e.d);
      end
    end
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic step(input logic [7:0] d, input logic v, input logic e);
    bus.data_in = d;
    bus.byte_valid = v;
    bus.sym_err = e;
    @(posedge clk_4f);
    #1;
  endtask
  always @(negedge clk_4f) begin
    if (mon_on) begin
      if (bus.active_to_PS !== prev_act) chk_ev(bus.active_to_PS ? K_RISE : K_FALL, 8'h00);
      prev_act = bus.active_to_PS;
      if (bus.slip_req) begin
        n_chk++;
        if (prev_slip) begin
          n_fail++;
          $display("FAIL slip_back_to_back: got 2 consecutive pulses required 1 at %0t", $time);
        end
        chk_ev(K_SLIP, 8'h00);
      end
      prev_slip = bus.slip_req;
      if (bus.valid_out_to_LDMX) chk_ev(K_PAY, bus.data2send_to_LDMX);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1;
    bus.enable = 1'b0;
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    chk("rst_state", bus.state_o, 0);
    chk("rst_active", bus.active_to_PS, 0);
    chk("rst_valid", bus.valid_out_to_LDMX, 0);
    chk("rst_slip", bus.slip_req, 0);
    chk("rst_data", bus.data2send_to_LDMX, 0);
    mon_on = 1'b1;
    reset = 1'b0;
    bus.enable = 1'b1;
    step(8'h00, 1'b0, 1'b0);
    chk("idle_to_search", bus.state_o, 1);
    // lock on four COMs, then forward one payload byte
    expect_ev(K_RISE, 8'h00);
    for (int i = 0; i < 4; i++) step(8'hBC, 1'b1, 1'b0);
    chk("t1_active", bus.state_o, 4);
    expect_ev(K_PAY, 8'h5A);
    step(8'h5A, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    // drop enable while active
    expect_ev(K_FALL, 8'h00);
    bus.enable = 1'b0;
    step(8'h00, 1'b0, 1'b0);
    chk("en_drop_state", bus.state_o, 0);
    bus.enable = 1'b1;
    step(8'h00, 1'b0, 1'b0);
    chk("en_resume_state", bus.state_o, 1);
    // two search windows, each ending in one slip
    for (int s = 0; s < 2; s++) begin
      expect_ev(K_SLIP, 8'h00);
      for (int i = 0; i < 15; i++) step(8'h00, 1'b1, 1'b0);
      chk("t2_still_search", bus.state_o, 1);
      step(8'h00, 1'b1, 1'b0);
      chk("t2_slip_state", bus.state_o, 2);
      step(8'h00, 1'b1, 1'b0);
      step(8'h00, 1'b1, 1'b0);
      chk("t2_slip_wait", bus.state_o, 2);
      step(8'h00, 1'b1, 1'b0);
      chk("t2_search_again", bus.state_o, 1);
    end
    // broken COM run returns to search without slip
    step(8'hBC, 1'b1, 1'b0);
    step(8'hBC, 1'b1, 1'b0);
    chk("t3_confirm", bus.state_o, 3);
    step(8'h11, 1'b1, 1'b0);
    chk("t3_back_search", bus.state_o, 1);
    expect_ev(K_RISE, 8'h00);
    for (int i = 0; i < 4; i++) step(8'hBC, 1'b1, 1'b0);
    chk("t3_active", bus.state_o, 4);
    // three consecutive errors lose lock
    step(8'h77, 1'b1, 1'b1);
    step(8'h78, 1'b1, 1'b1);
    chk("t4_two_err_active", bus.state_o, 4);
    expect_ev(K_FALL, 8'h00);
    step(8'h79, 1'b1, 1'b1);
    chk("t4_loss_state", bus.state_o, 1);
    expect_ev(K_RISE, 8'h00);
    for (int i = 0; i < 4; i++) step(8'hBC, 1'b1, 1'b0);
    // a clean byte between error pairs keeps lock
    step(8'h81, 1'b1, 1'b1);
    step(8'h82, 1'b1, 1'b1);
    expect_ev(K_PAY, 8'h3C);
    step(8'h3C, 1'b1, 1'b0);
    step(8'h83, 1'b1, 1'b1);
    step(8'h84, 1'b1, 1'b1);
    chk("t4_stays_active", bus.state_o, 4);
    expect_ev(K_PAY, 8'hA5);
    step(8'hA5, 1'b1, 1'b0);
    step(8'hBC, 1'b1, 1'b0);
    step(8'h99, 1'b0, 1'b0);
    chk("t4_data_hold", bus.data2send_to_LDMX, 8'hA5);
    // reset while active
    expect_ev(K_FALL, 8'h00);
    reset = 1'b1;
    step(8'h00, 1'b0, 1'b0);
    chk("t5_rst_act_state", bus.state_o, 0);
    chk("t5_rst_act_data", bus.data2send_to_LDMX, 0);
    reset = 1'b0;
    step(8'h00, 1'b0, 1'b0);
    // reset while slipping
    expect_ev(K_SLIP, 8'h00);
    for (int i = 0; i < 16; i++) step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    chk("t5_in_slip", bus.state_o, 2);
    reset = 1'b1;
    step(8'h00, 1'b0, 1'b0);
    chk("t5_rst_slip_state", bus.state_o, 0);
    chk("t5_rst_slip_req", bus.slip_req, 0);
    reset = 1'b0;
    step(8'h00, 1'b0, 1'b0);
`ifdef RX_LINK_STATS_EN
    chk("st_slip_clear", bus.slip_count, 0);
    chk("st_loss_clear", bus.lock_loss_count, 0);
    for (int n = 0; n < 2; n++) begin
      expect_ev(K_RISE, 8'h00);
      for (int i = 0; i < 4; i++) step(8'hBC, 1'b1, 1'b0);
      expect_ev(K_FALL, 8'h00);
      for (int i = 0; i < 3; i++) step(8'h55, 1'b1, 1'b1);
    end
    chk("st_loss_two", bus.lock_loss_count, 2);
    for (int n = 0; n < 300; n++) begin
      expect_ev(K_SLIP, 8'h00);
      for (int i = 0; i < 16; i++) step(8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b0);
    end
    chk("st_slip_sat", bus.slip_count, 8'hFF);
    chk("st_loss_hold", bus.lock_loss_count, 2);
`endif
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
